fft_butterfly: RTL and testbench



---
 rtl/fft_butterfly.sv | 200 ++++++++++++++++++++
 tb/tb_fft_butterfly.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly, four-stage pipeline: X = A + W*B, Y = A - W*B, saturated to DATA_W.
// Optional build macro FFT_BFLY_SCALE_EN halves x and y before saturation.
module fft_butterfly #(
  parameter int DATA_W  = 16,
  parameter int TW_W    = 16,
  parameter int TW_FRAC = 7,
  parameter int ADDR_W  = 9,
  parameter int IDX_W   = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_tw_addr,
  input  logic signed [DATA_W-1:0] in_a_re,
  input  logic signed [DATA_W-1:0] in_a_im,
  input  logic signed [DATA_W-1:0] in_b_re,
  input  logic signed [DATA_W-1:0] in_b_im,
  input  logic [IDX_W-1:0]         in_idx_a,
  input  logic [IDX_W-1:0]         in_idx_b,
  output logic [ADDR_W-1:0]        tw_addr,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_x_re,
  output logic signed [DATA_W-1:0] out_x_im,
  output logic signed [DATA_W-1:0] out_y_re,
  output logic signed [DATA_W-1:0] out_y_im,
  output logic [IDX_W-1:0]         out_idx_a,
  output logic [IDX_W-1:0]         out_idx_b,
  output logic                     busy,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  // Handshake: valid-only stream. A butterfly is taken on every edge where in_valid=1;
  // there is no ready, results appear with out_valid exactly three edges later.
  localparam int P_W = DATA_W + TW_W;
  localparam int S_W = P_W + 1;
  localparam int E_W = DATA_W + 2;

  // Returns {clip, saturated value}; clip when the upper bits are not a pure sign extension.
  function automatic logic [DATA_W:0] sat_fn(input logic signed [E_W-1:0] v);
    logic all_one;
    logic all_zero;
    all_one  = &v[E_W-1:DATA_W-1];
    all_zero = ~|v[E_W-1:DATA_W-1];
    if (all_one || all_zero) begin
      sat_fn = {1'b0, v[DATA_W-1:0]};
    end else if (v[E_W-1]) begin
      sat_fn = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_fn = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  logic                     r_s0_valid, r_s1_valid, r_s2_valid, r_out_valid;
  logic signed [DATA_W-1:0] r_s0_a_re, r_s0_a_im, r_s0_b_re, r_s0_b_im;
  logic [IDX_W-1:0]         r_s0_idx_a, r_s0_idx_b;
  logic signed [P_W-1:0]    r_s1_p_rr, r_s1_p_ii, r_s1_p_ri, r_s1_p_ir;
  logic signed [DATA_W-1:0] r_s1_a_re, r_s1_a_im;
  logic [IDX_W-1:0]         r_s1_idx_a, r_s1_idx_b;
  logic signed [E_W-1:0]    r_s2_wb_re, r_s2_wb_im;
  logic signed [DATA_W-1:0] r_s2_a_re, r_s2_a_im;
  logic [IDX_W-1:0]         r_s2_idx_a, r_s2_idx_b;
  logic signed [DATA_W-1:0] r_x_re, r_x_im, r_y_re, r_y_im;
  logic [IDX_W-1:0]         r_idx_a, r_idx_b;
  logic                     r_ovf;

  logic signed [P_W-1:0]    w_b_re_x, w_b_im_x, w_tw_re_x, w_tw_im_x;
  logic signed [P_W-1:0]    w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [S_W-1:0]    w_sum_re, w_sum_im;
  logic signed [E_W-1:0]    w_a_re_x, w_a_im_x;
  logic signed [E_W-1:0]    w_x_re, w_x_im, w_y_re, w_y_im;
  logic signed [E_W-1:0]    w_xs_re, w_xs_im, w_ys_re, w_ys_im;
  logic [DATA_W:0]          w_sat_xr, w_sat_xi, w_sat_yr, w_sat_yi;
  logic                     w_clip;

  // The ROM is registered, so the address must leave combinationally in the issue cycle.
  assign tw_addr = in_tw_addr;

  assign w_b_re_x  = $signed({{TW_W{r_s0_b_re[DATA_W-1]}}, r_s0_b_re});
  assign w_b_im_x  = $signed({{TW_W{r_s0_b_im[DATA_W-1]}}, r_s0_b_im});
  assign w_tw_re_x = $signed({{DATA_W{tw_re[TW_W-1]}}, tw_re});
  assign w_tw_im_x = $signed({{DATA_W{tw_im[TW_W-1]}}, tw_im});
  assign w_p_rr    = w_b_re_x * w_tw_re_x;
  assign w_p_ii    = w_b_im_x * w_tw_im_x;
  assign w_p_ri    = w_b_re_x * w_tw_im_x;
  assign w_p_ir    = w_b_im_x * w_tw_re_x;

  assign w_sum_re = $signed({r_s1_p_rr[P_W-1], r_s1_p_rr}) - $signed({r_s1_p_ii[P_W-1], r_s1_p_ii});
  assign w_sum_im = $signed({r_s1_p_ri[P_W-1], r_s1_p_ri}) + $signed({r_s1_p_ir[P_W-1], r_s1_p_ir});

  assign w_a_re_x = $signed({{2{r_s2_a_re[DATA_W-1]}}, r_s2_a_re});
  assign w_a_im_x = $signed({{2{r_s2_a_im[DATA_W-1]}}, r_s2_a_im});
  assign w_x_re   = w_a_re_x + r_s2_wb_re;
  assign w_x_im   = w_a_im_x + r_s2_wb_im;
  assign w_y_re   = w_a_re_x - r_s2_wb_re;
  assign w_y_im   = w_a_im_x - r_s2_wb_im;

`ifdef FFT_BFLY_SCALE_EN
  assign w_xs_re = w_x_re >>> 1;
  assign w_xs_im = w_x_im >>> 1;
  assign w_ys_re = w_y_re >>> 1;
  assign w_ys_im = w_y_im >>> 1;
`else
  assign w_xs_re = w_x_re;
  assign w_xs_im = w_x_im;
  assign w_ys_re = w_y_re;
  assign w_ys_im = w_y_im;
`endif

  assign w_sat_xr = sat_fn(w_xs_re);
  assign w_sat_xi = sat_fn(w_xs_im);
  assign w_sat_yr = sat_fn(w_ys_re);
  assign w_sat_yi = sat_fn(w_ys_im);
  assign w_clip   = w_sat_xr[DATA_W] | w_sat_xi[DATA_W] | w_sat_yr[DATA_W] | w_sat_yi[DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_s0_valid <= in_valid;
      r_s1_valid <= r_s0_valid;
      r_s2_valid <= r_s1_valid;
      r_out_valid <= r_s2_valid;
    end
  end

  // Data stages only load on a valid slot so idle ROM outputs never reach the datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_a_re <= '0; r_s0_a_im <= '0; r_s0_b_re <= '0; r_s0_b_im <= '0;
      r_s0_idx_a <= '0; r_s0_idx_b <= '0;
    end else if (in_valid) begin
      r_s0_a_re <= in_a_re; r_s0_a_im <= in_a_im;
      r_s0_b_re <= in_b_re; r_s0_b_im <= in_b_im;
      r_s0_idx_a <= in_idx_a; r_s0_idx_b <= in_idx_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_p_rr <= '0; r_s1_p_ii <= '0; r_s1_p_ri <= '0; r_s1_p_ir <= '0;
      r_s1_a_re <= '0; r_s1_a_im <= '0; r_s1_idx_a <= '0; r_s1_idx_b <= '0;
    end else if (r_s0_valid) begin
      r_s1_p_rr <= w_p_rr; r_s1_p_ii <= w_p_ii;
      r_s1_p_ri <= w_p_ri; r_s1_p_ir <= w_p_ir;
      r_s1_a_re <= r_s0_a_re; r_s1_a_im <= r_s0_a_im;
      r_s1_idx_a <= r_s0_idx_a; r_s1_idx_b <= r_s0_idx_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_wb_re <= '0; r_s2_wb_im <= '0;
      r_s2_a_re <= '0; r_s2_a_im <= '0; r_s2_idx_a <= '0; r_s2_idx_b <= '0;
    end else if (r_s1_valid) begin
      r_s2_wb_re <= E_W'(w_sum_re >>> TW_FRAC);
      r_s2_wb_im <= E_W'(w_sum_im >>> TW_FRAC);
      r_s2_a_re <= r_s1_a_re; r_s2_a_im <= r_s1_a_im;
      r_s2_idx_a <= r_s1_idx_a; r_s2_idx_b <= r_s1_idx_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_re <= '0; r_x_im <= '0; r_y_re <= '0; r_y_im <= '0;
      r_idx_a <= '0; r_idx_b <= '0;
    end else if (r_s2_valid) begin
      r_x_re <= w_sat_xr[DATA_W-1:0]; r_x_im <= w_sat_xi[DATA_W-1:0];
      r_y_re <= w_sat_yr[DATA_W-1:0]; r_y_im <= w_sat_yi[DATA_W-1:0];
      r_idx_a <= r_s2_idx_a; r_idx_b <= r_s2_idx_b;
    end
  end

  // A fresh clip outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (r_s2_valid && w_clip) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_x_re  = r_x_re;
  assign out_x_im  = r_x_im;
  assign out_y_re  = r_y_re;
  assign out_y_im  = r_y_im;
  assign out_idx_a = r_idx_a;
  assign out_idx_b = r_idx_b;
  assign busy      = r_s0_valid | r_s1_valid | r_s2_valid | r_out_valid;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly with a registered twiddle ROM model.
// Expectations follow FFT_BFLY_SCALE_EN when the build defines it.
module tb_fft_butterfly;
  localparam int DATA_W = 16;
  localparam int TW_W = 16;
  localparam int ADDR_W = 9;
  localparam int IDX_W = 10;
  localparam int EXP_W = 4 * DATA_W + 2 * IDX_W;

  typedef struct packed {
    logic signed [DATA_W-1:0] xr;
    logic signed [DATA_W-1:0] xi;
    logic signed [DATA_W-1:0] yr;
    logic signed [DATA_W-1:0] yi;
    logic [IDX_W-1:0]         ia;
    logic [IDX_W-1:0]         ib;
  } res_t;

  logic clk, reset_n, in_valid, clr_ovf;
  logic [ADDR_W-1:0] in_tw_addr, tw_addr;
  logic signed [DATA_W-1:0] in_a_re, in_a_im, in_b_re, in_b_im;
  logic [IDX_W-1:0] in_idx_a, in_idx_b, out_idx_a, out_idx_b;
  logic signed [TW_W-1:0] tw_re, tw_im;
  logic out_valid, busy, ovf;
  logic signed [DATA_W-1:0] out_x_re, out_x_im, out_y_re, out_y_im;

  fft_butterfly dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_tw_addr(in_tw_addr),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .in_idx_a(in_idx_a), .in_idx_b(in_idx_b), .tw_addr(tw_addr),
    .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid),
    .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im),
    .out_idx_a(out_idx_a), .out_idx_b(out_idx_b), .busy(busy), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  // ---------------- clock / reset / ROM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [TW_W-1:0] rom_re [2**ADDR_W];
  logic signed [TW_W-1:0] rom_im [2**ADDR_W];
  always @(posedge clk) begin
    tw_re <= rom_re[tw_addr];
    tw_im <= rom_im[tw_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int lat_q[$];
  int checks = 0;
  int errors = 0;
  int out_seen = 0;
  bit stream_on = 0;
  int out_cyc [64];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint sat16(input longint v, output bit c);
    c = 1'b0;
    if (v > 32767) begin c = 1'b1; return 32767; end
    if (v < -32768) begin c = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic res_t model(input longint ar, ai, br, bi, wr, wi,
                                 input logic [IDX_W-1:0] ia, ib);
    longint wbr, wbi, v[4];
    bit c;
    res_t r;
    wbr = floor_div(br * wr - bi * wi, 128);
    wbi = floor_div(br * wi + bi * wr, 128);
    v[0] = ar + wbr; v[1] = ai + wbi; v[2] = ar - wbr; v[3] = ai - wbi;
`ifdef FFT_BFLY_SCALE_EN
    for (int k = 0; k < 4; k++) v[k] = floor_div(v[k], 2);
`endif
    r.xr = 16'(sat16(v[0], c)); r.xi = 16'(sat16(v[1], c));
    r.yr = 16'(sat16(v[2], c)); r.yi = 16'(sat16(v[3], c));
    r.ia = ia; r.ib = ib;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input longint ar, ai, br, bi, input int addr,
                          input int ia, ib, input res_t exp);
    @(negedge clk);
    in_valid = 1'b1;
    in_a_re = 16'(ar); in_a_im = 16'(ai); in_b_re = 16'(br); in_b_im = 16'(bi);
    in_tw_addr = ADDR_W'(addr); in_idx_a = IDX_W'(ia); in_idx_b = IDX_W'(ib);
    exp_q.push_back(exp);
    lat_q.push_back(cyc + 1);
    #1;
    check("tw_addr", tw_addr, addr);
  endtask

  task automatic drive_model(input longint ar, ai, br, bi, input int addr, input int ia, ib);
    res_t e;
    e = model(ar, ai, br, bi, rom_re[addr], rom_im[addr], IDX_W'(ia), IDX_W'(ib));
    drive_op(ar, ai, br, bi, addr, ia, ib, e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  function automatic res_t mk(input longint xr, xi, yr, yi, input int ia, ib);
    res_t r;
    r.xr = 16'(xr); r.xi = 16'(xi); r.yr = 16'(yr); r.yi = 16'(yi);
    r.ia = IDX_W'(ia); r.ib = IDX_W'(ib);
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      res_t e;
      res_t a;
      int iss;
      out_seen++;
      a = '{out_x_re, out_x_im, out_y_re, out_y_im, out_idx_a, out_idx_b};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: idx_a=%0d with empty expected queue", out_idx_a);
      end else begin
        e = res_t'(exp_q.pop_front());
        iss = lat_q.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL result: got x=(%0d,%0d) y=(%0d,%0d) idx=(%0d,%0d) expected x=(%0d,%0d) y=(%0d,%0d) idx=(%0d,%0d)",
                   a.xr, a.xi, a.yr, a.yi, a.ia, a.ib, e.xr, e.xi, e.yr, e.yi, e.ia, e.ib);
        end
        check("latency", cyc - iss, 3);
        if (stream_on && out_idx_a < 64) out_cyc[out_idx_a] = cyc;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int seen0;
    in_valid = 0; clr_ovf = 0; in_tw_addr = '0;
    in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
    in_idx_a = '0; in_idx_b = '0;
    tw_re = '0; tw_im = '0;
    for (int k = 0; k < 2**ADDR_W; k++) begin
      rom_re[k] = 16'($signed($urandom_range(0, 254)) - 127);
      rom_im[k] = 16'($signed($urandom_range(0, 254)) - 127);
    end
    rom_re[0] = 16'sd127; rom_im[0] = 16'sd0;
    rom_re[1] = 16'sd0;   rom_im[1] = -16'sd127;
    reset_n = 0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);
    check("reset_x_re", out_x_re, 0);
    check("reset_idx_a", out_idx_a, 0);
    reset_n = 1;
    idle(2);

`ifdef FFT_BFLY_SCALE_EN
    drive_op(100, 0, 50, 0, 0, 1, 2, mk(74, 0, 25, 0, 1, 2));
    drive_op(100, 0, 50, 0, 1, 3, 4, mk(50, -25, 50, 25, 3, 4));
`else
    drive_op(100, 0, 50, 0, 0, 1, 2, mk(149, 0, 51, 0, 1, 2));
    drive_op(100, 0, 50, 0, 1, 3, 4, mk(100, -50, 100, 50, 3, 4));
`endif
    idle(1);
    check("busy_in_flight", busy, 1);
    idle(6);
    check("ovf_after_clean", ovf, 0);

    // saturation
`ifdef FFT_BFLY_SCALE_EN
    drive_op(32767, 0, 32767, 0, 0, 5, 6, mk(32639, 0, 128, 0, 5, 6));
    idle(6);
    check("ovf_after_sat", ovf, 0);
`else
    drive_op(32767, 0, 32767, 0, 0, 5, 6, mk(32767, 0, 256, 0, 5, 6));
    idle(6);
    check("ovf_after_sat", ovf, 1);
`endif
    @(negedge clk); clr_ovf = 1;
    @(negedge clk); clr_ovf = 0;
    check("ovf_cleared", ovf, 0);

    // clear in the very cycle the clipping result is written
`ifdef FFT_BFLY_SCALE_EN
    drive_op(32767, 0, 32767, 0, 0, 7, 8, mk(32639, 0, 128, 0, 7, 8));
`else
    drive_op(32767, 0, 32767, 0, 0, 7, 8, mk(32767, 0, 256, 0, 7, 8));
`endif
    idle(2);
    @(negedge clk); in_valid = 0; clr_ovf = 1;
    @(negedge clk); clr_ovf = 0;
`ifdef FFT_BFLY_SCALE_EN
    check("ovf_set_wins", ovf, 0);
`else
    check("ovf_set_wins", ovf, 1);
`endif
    idle(4);
    check("queue_empty_directed", exp_q.size(), 0);

    // reset with three operations in flight
    drive_model(1000, -200, 300, 400, 10, 11, 12);
    drive_model(-500, 600, 700, -800, 11, 13, 14);
    drive_model(20, 30, -40, 50, 12, 15, 16);
    @(negedge clk);
    in_valid = 0;
    check("busy_before_reset", busy, 1);
    reset_n = 0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_x_re", out_x_re, 0);
    check("rst_x_im", out_x_im, 0);
    check("rst_y_re", out_y_re, 0);
    check("rst_y_im", out_y_im, 0);
    check("rst_idx_a", out_idx_a, 0);
    check("rst_idx_b", out_idx_b, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    seen0 = out_seen;
    idle(8);
    check("no_stale_after_reset", out_seen - seen0, 0);

    // streaming with a one-cycle bubble before op 20
    stream_on = 1;
    seen0 = out_seen;
    for (int i = 0; i < 64; i++) begin
      if (i == 20) idle(1);
      drive_model($signed(16'($urandom_range(0, 65535))), $signed(16'($urandom_range(0, 65535))),
                  $signed(16'($urandom_range(0, 65535))), $signed(16'($urandom_range(0, 65535))),
                  int'($urandom_range(2, 511)), i, i + 100);
    end
    idle(10);
    stream_on = 0;
    check("stream_count", out_seen - seen0, 64);
    check("stream_b2b_0_1", out_cyc[1] - out_cyc[0], 1);
    check("stream_b2b_18_19", out_cyc[19] - out_cyc[18], 1);
    check("stream_bubble_19_20", out_cyc[20] - out_cyc[19], 2);
    check("stream_b2b_20_21", out_cyc[21] - out_cyc[20], 1);
    check("stream_b2b_62_63", out_cyc[63] - out_cyc[62], 1);
    check("queue_empty_final", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
